tff_toggle_gen: RTL
===================

Name: tff_toggle_gen

Overview:
Upstream stage for the toggle flip-flop: turns a raw, bouncing push-button level into clean single-cycle toggle pulses that drive a T input.
- Path: synchroniser -> debounce FSM -> one-cycle pulse.
- Optional auto-repeat while the button is held.
- Keeps a wrapping count of pulses issued, for status and debug.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on btn_in (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a press or a release (>=1)
REPEAT_EN, 1, 1 = auto-repeat pulses while held; 0 = one pulse per press
REPEAT_DELAY, 16, cycles from entering HELD to the first repeat pulse
REPEAT_PERIOD, 8, cycles between later repeat pulses
CNT_W, 8, width of t_count

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
en  input  1  enable; low forces idle
btn_in  input  1  raw asynchronous button level, active-high
t_out  output  1  one-cycle toggle pulse; drives the TFF T input
btn_level  output  1  debounced button level
busy  output  1  high whenever the FSM is not in IDLE
t_count  output  CNT_W  number of t_out pulses issued, wrapping

Behaviour:
- Reset (rst=0 at a clk edge):
  - sync chain = 0, FSM = IDLE, debounce and repeat counters = 0.
  - t_out = 0, btn_level = 0, busy = 0, t_count = 0.
  - Reset overrides everything, including mid-press; no pulse is issued on reset exit.
- Synchroniser: btn_s is the output of SYNC_STAGES flops in series; the FSM sees only btn_s.
- All outputs are registered.
- FSM states:
  - IDLE: btn_s=1 -> PRESS_DB, db_cnt=0.
  - PRESS_DB: btn_s=0 -> IDLE, no pulse (bounce rejected).
    - Else if db_cnt==DEBOUNCE_CYCLES-1 -> HELD; t_out<=1, btn_level<=1, rep_cnt=0.
    - Else db_cnt++.
  - HELD: btn_s=0 -> REL_DB, db_cnt=0.
    - Else, if REPEAT_EN: rep_cnt++. Issue a pulse when rep_cnt reaches REPEAT_DELAY-1 for the first repeat and REPEAT_PERIOD-1 for later repeats; rep_cnt reloads to 0 on each pulse.
  - REL_DB: btn_s=1 -> HELD, no pulse, rep_cnt=0 (repeat delay restarts).
    - Else if db_cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0.
    - Else db_cnt++.
- t_out is high for exactly one cycle per pulse and never high on two consecutive cycles.
- Latency: with btn_in high and stable from edge k, t_out is high in the cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES (default: edge k+6).
- Release latency to btn_level=0 is the same count.
- en=0:
  - FSM forced to IDLE; counters cleared; t_out=0; btn_level=0.
  - t_count holds its value; the sync chain keeps running.
  - When en rises with the button held, a fresh full debounce runs before the first pulse.
- t_count:
  - Increments by 1 in the same cycle t_out is high.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- busy = (state != IDLE).

Decomposition:
- Package tff_toggle_pkg holds:
  - state enum {IDLE, PRESS_DB, HELD, REL_DB}, 2-bit encoding;
  - default constants for the debounce and repeat timing.
- Counter widths are derived with $clog2 of the maximum of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
- One sub-module, bit_sync: a parameterised SYNC_STAGES flop chain with synchronous active-low reset. It is reusable for other async inputs.

Test Plan:
- Reset: hold rst=0 for 3 cycles with btn_in=1 -> all outputs 0. After rst=1, the first t_out arrives 6 cycles later (defaults); none arrives earlier.
- Bounce rejection: btn_in high for 2 cycles, low, then high for 3 cycles, low -> t_out never high, t_count=0, btn_level stays 0.
- Clean press with REPEAT_EN=0: btn_in high for 20 cycles from edge k -> exactly one t_out, in the cycle after edge k+6; t_count=1. btn_level falls 6 cycles after btn_in falls.
- Auto-repeat with defaults: btn_in held for 40 cycles from edge k -> pulses after edges k+6, k+22, k+30 and k+38; t_count=4.
- Mid-operation events:
  - rst=0 during HELD -> everything cleared next edge; no pulse on release.
  - en=0 during HELD -> t_out=0 and t_count frozen; on en=1 with the button held, the next pulse comes DEBOUNCE_CYCLES+1 cycles later.
- Wrap: with CNT_W=2, five clean presses -> t_count reads 1,2,3,0,1.

Source files
------------

// File: rtl/tff_toggle_pkg.sv
// Shared types and default timing for the push-button toggle pulse generator.
// Counter widths are sized from the longest timing interval via timer_width().
package tff_toggle_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressDb = 2'd1,
        StHeld    = 2'd2,
        StRelDb   = 2'd3
    } tff_state_e;

    localparam int unsigned DefSyncStages    = 2;
    localparam int unsigned DefDebounceCycles = 4;
    localparam int unsigned DefRepeatDelay    = 16;
    localparam int unsigned DefRepeatPeriod   = 8;

    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        // Counters only ever hold values up to m-1; keep at least one bit.
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous input bit.
// Synchronous active-low reset clears the whole chain.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/tff_toggle_gen.sv
// Debounced push-button to single-cycle toggle pulse generator with optional auto-repeat.
// Path: bit_sync -> debounce FSM -> registered pulse, plus a wrapping pulse counter.
module tff_toggle_gen
    import tff_toggle_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             btn_in,
    output logic             t_out,
    output logic             btn_level,
    output logic             busy,
    output logic [CNT_W-1:0] t_count
);

    localparam int unsigned TimerW = timer_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [TimerW-1:0] DbLast     = TimerW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TimerW-1:0] DelayLast  = TimerW'(REPEAT_DELAY - 1);
    localparam logic [TimerW-1:0] PeriodLast = TimerW'(REPEAT_PERIOD - 1);

    logic btn_s;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_bit_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_in),
        .q  (btn_s)
    );

    tff_state_e        state_q, state_d;
    logic [TimerW-1:0] db_cnt_q, db_cnt_d;
    logic [TimerW-1:0] rep_cnt_q, rep_cnt_d;
    logic              first_q, first_d;   // next repeat uses the initial delay
    logic              t_out_q, t_out_d;
    logic              btn_level_q, btn_level_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  t_count_q, t_count_d;
    logic              pulse;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            first_q     <= 1'b1;
            t_out_q     <= 1'b0;
            btn_level_q <= 1'b0;
            busy_q      <= 1'b0;
            t_count_q   <= '0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            first_q     <= first_d;
            t_out_q     <= t_out_d;
            btn_level_q <= btn_level_d;
            busy_q      <= busy_d;
            t_count_q   <= t_count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rep_cnt_d = rep_cnt_q;
        first_d   = first_q;
        pulse     = 1'b0;
        if (!en) begin
            state_d   = StIdle;
            db_cnt_d  = '0;
            rep_cnt_d = '0;
            first_d   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (btn_s) begin
                        state_d  = StPressDb;
                        db_cnt_d = '0;
                    end
                end
                StPressDb: begin
                    if (!btn_s) begin
                        state_d = StIdle;
                    end else if (db_cnt_q == DbLast) begin
                        state_d   = StHeld;
                        rep_cnt_d = '0;
                        first_d   = 1'b1;
                        pulse     = 1'b1;
                    end else begin
                        db_cnt_d = db_cnt_q + TimerW'(1);
                    end
                end
                StHeld: begin
                    if (!btn_s) begin
                        state_d  = StRelDb;
                        db_cnt_d = '0;
                    end else if (REPEAT_EN) begin
                        if (rep_cnt_q == (first_q ? DelayLast : PeriodLast)) begin
                            pulse     = 1'b1;
                            rep_cnt_d = '0;
                            first_d   = 1'b0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + TimerW'(1);
                        end
                    end
                end
                StRelDb: begin
                    // A bounce back to pressed restarts the repeat delay from scratch.
                    if (btn_s) begin
                        state_d   = StHeld;
                        rep_cnt_d = '0;
                        first_d   = 1'b1;
                    end else if (db_cnt_q == DbLast) begin
                        state_d = StIdle;
                    end else begin
                        db_cnt_d = db_cnt_q + TimerW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        t_out_d     = pulse;
        btn_level_d = (state_d == StHeld) || (state_d == StRelDb);
        busy_d      = (state_d != StIdle);
        t_count_d   = t_count_q + CNT_W'(pulse);
    end

    assign t_out     = t_out_q;
    assign btn_level = btn_level_q;
    assign busy      = busy_q;
    assign t_count   = t_count_q;

endmodule
